// File: rtl/sipo_word_assembler_if.sv
// Parallel-side bundle of the serial-to-parallel word assembler.
// master = the assembler itself, slave = the frame source / word consumer.
interface sipo_word_assembler_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic             sin;
    logic             sin_en;
    logic [WIDTH-1:0] out;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             overrun;

    modport master (
        input  start, sin, sin_en, out_ready,
        output out, out_valid, busy, overrun
    );

    modport slave (
        output start, sin, sin_en, out_ready,
        input  out, out_valid, busy, overrun
    );
endinterface

// File: rtl/sipo_word_assembler.sv
// Collects a framed serial bit stream into WIDTH-bit words and holds each
// finished word on a valid/ready output stage feeding the PIPO register.
module sipo_word_assembler #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    sipo_word_assembler_if.master bus
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] next_word;
    logic [WIDTH-1:0] out_q;
    logic             out_valid_q;
    logic             overrun_q;
    logic             complete;

    // NOTE: pure combinational helpers use always_comb with a default assignment
    // for every variable first, so no path can leave a value held (no latch).
    always_comb begin
        next_word = shreg;
        if (MSB_FIRST)
            next_word = {shreg[WIDTH-2:0], bus.sin};
        else
            next_word = {bus.sin, shreg[WIDTH-1:1]};
    end

    // start outranks sin_en, so a restart cycle can never complete a word.
    assign complete = (state == SHIFT) && !bus.start && bus.sin_en && (count == LAST);

    // NOTE: all state below is updated with non-blocking assignments so every
    // register samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            shreg       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state <= SHIFT;
                        count <= '0;
                        shreg <= '0;
                    end
                end
                default: begin
                    if (bus.start) begin
                        count <= '0;
                        shreg <= '0;
                    end else if (bus.sin_en) begin
                        shreg <= next_word;
                        if (count == LAST) begin
                            state <= IDLE;
                            count <= '0;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
            endcase

            // A completed word only displaces the held one if it is consumed on this edge.
            if (complete) begin
                if (!out_valid_q || bus.out_ready) begin
                    out_q       <= next_word;
                    out_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = (state == SHIFT);
endmodule

// File: tb/tb_sipo_word_assembler.sv
// Drives identical framed streams into an MSB-first and an LSB-first assembler
// and scoreboards both against a bit-list reference model.
module tb_sipo_word_assembler;
    localparam int W = 4;

    typedef struct {
        logic [W-1:0] out;
        logic         vld;
        logic         busy;
        logic         ovr;
    } stat_t;

    logic clk = 1'b0;
    logic rst;

    sipo_word_assembler_if #(.WIDTH(W)) if0 ();
    sipo_word_assembler_if #(.WIDTH(W)) if1 ();

    sipo_word_assembler #(.WIDTH(W), .MSB_FIRST(1'b1)) dut0 (.clk(clk), .rst(rst), .bus(if0));
    sipo_word_assembler #(.WIDTH(W), .MSB_FIRST(1'b0)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    stat_t        sq0[$];
    stat_t        sq1[$];
    logic [W-1:0] wq0[$];
    logic [W-1:0] wq1[$];

    // Reference model: the frame is a list of received bits; words are formed arithmetically.
    bit           m_in_frame;
    bit           m_bits[$];
    logic [W-1:0] m_out[2];
    bit           m_vld[2];
    bit           m_ovr[2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit st, input bit b, input bit en, input bit rdy);
        bit           done = 0;
        logic [W-1:0] w[2];
        int           msb_val = 0;
        int           lsb_val = 0;
        if (r) begin
            m_in_frame = 0;
            m_bits.delete();
            for (int d = 0; d < 2; d++) begin
                m_out[d] = '0;
                m_vld[d] = 0;
                m_ovr[d] = 0;
            end
        end else begin
            if (!m_in_frame) begin
                if (st) begin
                    m_in_frame = 1;
                    m_bits.delete();
                end
            end else if (st) begin
                m_bits.delete();
            end else if (en) begin
                m_bits.push_back(b);
                if (m_bits.size() == W) begin
                    for (int i = 0; i < W; i++) begin
                        msb_val = msb_val * 2 + int'(m_bits[i]);
                        lsb_val = lsb_val + (int'(m_bits[i]) << i);
                    end
                    w[0] = W'(msb_val);
                    w[1] = W'(lsb_val);
                    done = 1;
                    m_in_frame = 0;
                    m_bits.delete();
                end
            end
            for (int d = 0; d < 2; d++) begin
                if (done) begin
                    if (!m_vld[d] || rdy) begin
                        m_out[d] = w[d];
                        m_vld[d] = 1;
                        if (d == 0) wq0.push_back(w[d]);
                        else        wq1.push_back(w[d]);
                    end else begin
                        m_ovr[d] = 1;
                    end
                end else if (m_vld[d] && rdy) begin
                    m_vld[d] = 0;
                end
            end
        end
        sq0.push_back('{out: m_out[0], vld: m_vld[0], busy: m_in_frame, ovr: m_ovr[0]});
        sq1.push_back('{out: m_out[1], vld: m_vld[1], busy: m_in_frame, ovr: m_ovr[1]});
    endtask

    task automatic cyc(input bit r, input bit st, input bit b, input bit en, input bit rdy);
        @(negedge clk);
        rst = r;
        if0.start = st; if0.sin = b; if0.sin_en = en; if0.out_ready = rdy;
        if1.start = st; if1.sin = b; if1.sin_en = en; if1.out_ready = rdy;
        model_step(r, st, b, en, rdy);
    endtask

    // Start a frame and send bits[W-1] first; ready only on the final bit edge if asked.
    task automatic send_word(input logic [W-1:0] bits, input bit rdy_last);
        cyc(0, 1, 0, 0, 0);
        for (int i = W - 1; i >= 0; i--)
            cyc(0, 0, bits[i], 1, (i == 0) ? rdy_last : 1'b0);
    endtask

    // Monitor: per-cycle status compare plus word scoreboard on each new presentation.
    bit pv0 = 0;
    bit pv1 = 0;
    initial begin
        stat_t s;
        logic [W-1:0] w;
        forever begin
            @(posedge clk);
            #1;
            if (sq0.size() > 0) begin
                s = sq0.pop_front();
                check("msb_out",     32'(if0.out),       32'(s.out));
                check("msb_valid",   32'(if0.out_valid), 32'(s.vld));
                check("msb_busy",    32'(if0.busy),      32'(s.busy));
                check("msb_overrun", 32'(if0.overrun),   32'(s.ovr));
            end
            if (sq1.size() > 0) begin
                s = sq1.pop_front();
                check("lsb_out",     32'(if1.out),       32'(s.out));
                check("lsb_valid",   32'(if1.out_valid), 32'(s.vld));
                check("lsb_busy",    32'(if1.busy),      32'(s.busy));
                check("lsb_overrun", 32'(if1.overrun),   32'(s.ovr));
            end
            if (if0.out_valid === 1'b1 && (!pv0 || if0.out_ready === 1'b1)) begin
                check("msb_word_expected", 32'(wq0.size() != 0), 32'd1);
                if (wq0.size() != 0) begin
                    w = wq0.pop_front();
                    check("msb_word", 32'(if0.out), 32'(w));
                end
            end
            if (if1.out_valid === 1'b1 && (!pv1 || if1.out_ready === 1'b1)) begin
                check("lsb_word_expected", 32'(wq1.size() != 0), 32'd1);
                if (wq1.size() != 0) begin
                    w = wq1.pop_front();
                    check("lsb_word", 32'(if1.out), 32'(w));
                end
            end
            pv0 = (if0.out_valid === 1'b1);
            pv1 = (if1.out_valid === 1'b1);
        end
    end

    initial begin
        rst = 1'b1;
        if0.start = 1; if0.sin = 1; if0.sin_en = 1; if0.out_ready = 0;
        if1.start = 1; if1.sin = 1; if1.sin_en = 1; if1.out_ready = 0;

        // Reset dominates start/sin_en.
        cyc(1, 1, 1, 1, 0);
        cyc(1, 1, 1, 1, 0);

        // Basic word 1,0,1,1 held, then consumed; out must persist.
        send_word(4'b1011, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);

        // sin_en in the start cycle from IDLE is ignored.
        cyc(0, 1, 1, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 1, 1, 1);

        // Gaps and restart: partial 1,1 discarded, then 0,1,1,0.
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 0);
        for (int i = 3; i >= 0; i--) begin
            cyc(0, 0, 0, 0, 0);
            cyc(0, 0, (4'b0110 >> i) & 1'b1, 1, 0);
        end
        cyc(0, 0, 0, 0, 1);

        // Overrun: 0xA pending, 0x5 dropped.
        send_word(4'hA, 0);
        send_word(4'h5, 0);
        cyc(0, 0, 0, 0, 0);
        // Same, but the second word is consumed-and-replaced on its completion edge.
        cyc(1, 0, 0, 0, 0);
        send_word(4'hA, 0);
        send_word(4'h5, 1);
        cyc(0, 0, 0, 0, 1);

        // Reset mid-frame, then a clean 0,0,0,1.
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 1, 0);
        cyc(0, 0, 1, 1, 0);
        cyc(1, 0, 0, 0, 0);
        send_word(4'b0001, 0);
        cyc(0, 0, 0, 0, 1);

        // Randomised traffic.
        for (int n = 0; n < 3000; n++)
            cyc($urandom_range(199, 0) == 0,
                $urandom_range(11, 0) == 0,
                1'($urandom_range(1, 0)),
                $urandom_range(99, 0) < 60,
                $urandom_range(99, 0) < 35);

        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("msb_status_drained", 32'(sq0.size()), 32'd0);
        check("lsb_status_drained", 32'(sq1.size()), 32'd0);
        check("msb_words_drained",  32'(wq0.size()), 32'd0);
        check("lsb_words_drained",  32'(wq1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
